// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command into one SETUP/ACCESS transfer
// and returns a single-cycle response pulse, with an optional ACCESS timeout.
module apb_master #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                    pclk,
    input  logic                    rstn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_timeout;

    // Abort on the ACCESS cycle that would make the stall count reach TIMEOUT.
    assign w_cnt_next = r_cnt + CNT_W'(1);
    assign w_timeout  = (TIMEOUT > 0) && (w_cnt_next == TO_VAL);

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            cmd_ready   <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_state   <= SETUP;
                        r_cnt     <= '0;
                        cmd_ready <= 1'b0;
                        psel      <= 1'b1;
                        penable   <= 1'b0;
                        pwrite    <= cmd_write;
                        paddr     <= cmd_addr;
                        pwdata    <= cmd_write ? cmd_wdata : '0;
                        pstrb     <= cmd_write ? cmd_strb  : '0;
                    end
                end
                SETUP: begin
                    r_state <= ACCESS;
                    penable <= 1'b1;
                end
                ACCESS: begin
                    if (pready) begin
                        r_state   <= IDLE;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        cmd_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_err   <= pslverr;
                        rsp_rdata <= pwrite ? '0 : prdata;
                    end else if (w_timeout) begin
                        r_state     <= IDLE;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        cmd_ready   <= 1'b1;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    psel      <= 1'b0;
                    penable   <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: hand-computed vectors for normal, wait-state,
// error, timeout, reset-abort and back-to-back transfers.
module tb_apb_master;

    logic        pclk = 1'b0;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_checks = 0;
    int n_errors = 0;

    apb_master #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .pclk(pclk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
        .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // One full transfer; waits = pready-low ACCESS cycles, exp_to = expect timeout abort.
    task automatic xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, input int waits, input logic serr,
                        input logic [31:0] rd, input logic exp_to);
        int nacc;
        logic [31:0] exp_wd;
        logic [3:0]  exp_st;
        nacc   = exp_to ? 16 : waits + 1;
        exp_wd = wr ? wd : 32'h0;
        exp_st = wr ? st : 4'h0;
        chk("idle_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st;
        pready = 1'b0; pslverr = 1'b0; prdata = 32'hDEAD_BEEF;
        step();
        // SETUP: garbage on the command and slave inputs must be ignored
        cmd_valid = 1'b1; cmd_addr = ~addr; cmd_wdata = ~wd; cmd_strb = ~st; cmd_write = ~wr;
        pready = 1'b1; pslverr = 1'b1;
        chk("setup_sel_en", {psel, penable, cmd_ready, rsp_valid}, 4'b1000);
        chk("setup_addr", paddr, addr);
        chk("setup_write", pwrite, wr);
        chk("setup_wdata", pwdata, exp_wd);
        chk("setup_strb", pstrb, exp_st);
        for (int i = 0; i < nacc; i++) begin
            step();
            cmd_valid = 1'b0;
            chk("acc_sel_en", {psel, penable, cmd_ready, rsp_valid}, 4'b1100);
            chk("acc_stable", {pwrite, paddr, pstrb, pwdata}, {wr, addr, exp_st, exp_wd});
            if (!exp_to && i == waits) begin
                pready = 1'b1; pslverr = serr; prdata = rd;
            end else begin
                pready = 1'b0; pslverr = 1'b1; prdata = 32'hDEAD_BEEF;
            end
        end
        step();
        pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
        chk("rsp_pulse", {rsp_valid, psel, penable, cmd_ready}, 4'b1001);
        chk("rsp_err", rsp_err, exp_to ? 1'b1 : serr);
        chk("rsp_timeout", rsp_timeout, exp_to);
        chk("rsp_rdata", rsp_rdata, (exp_to || wr) ? 32'h0 : rd);
        step();
        chk("rsp_clear", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, 35'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_strb = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        #12;
        chk("rst_ctrl", {cmd_ready, psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout}, 7'b1000000);
        chk("rst_data", {paddr, pwdata, pstrb, rsp_rdata}, 80'h0);
        step();
        rstn = 1'b1;
        step();

        xfer(1'b1, 12'h004, 32'hA5A5_5A5A, 4'hF, 0, 1'b0, 32'h0, 1'b0);  // zero-wait write
        xfer(1'b0, 12'hFE0, 32'h1234_5678, 4'h5, 3, 1'b0, 32'h19, 1'b0); // waited read
        xfer(1'b1, 12'h100, 32'h0000_0001, 4'h3, 1, 1'b1, 32'h0, 1'b0);  // slave error
        xfer(1'b0, 12'h200, 32'h0, 4'h0, 0, 1'b0, 32'h0, 1'b1);          // timeout abort
        xfer(1'b0, 12'h208, 32'h0, 4'h0, 15, 1'b0, 32'hCAFE_F00D, 1'b0); // ready on 16th cycle

        // Reset in the middle of ACCESS
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h00C; cmd_wdata = 32'h55; cmd_strb = 4'h1;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        chk("pre_rst_access", {psel, penable}, 2'b11);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst", {psel, penable, cmd_ready, rsp_valid}, 4'b0010);
        pready = 1'b1; pslverr = 1'b1; prdata = 32'hFFFF_FFFF;
        step();
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_quiet", {rsp_valid, psel, penable, cmd_ready}, 4'b0001);
        end
        xfer(1'b0, 12'h010, 32'h0, 4'h0, 1, 1'b0, 32'h0BAD_F00D, 1'b0);

        // Back-to-back with cmd_valid held and a zero-wait slave
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h020; cmd_wdata = 32'h77; cmd_strb = 4'hF;
        pready = 1'b1; pslverr = 1'b0; prdata = 32'h0;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 12) cmd_valid = 1'b0;
            chk("b2b_rsp", rsp_valid, (c % 3) == 0);
            chk("b2b_ready", {cmd_ready, psel}, ((c % 3) == 0) ? 2'b10 : 2'b01);
        end
        pready = 1'b0;
        step();
        step();
        chk("b2b_end_idle", {cmd_ready, psel, rsp_valid}, 3'b100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
